// File: rtl/math_decode_seq_pkg.sv
// Shared definitions for the math_decode_seq slice: FSM state encodings,
// divider iteration count and the saturation-threshold helper.
package math_decode_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_SUB    = 2'd2;
  localparam logic [1:0] ST_MUL    = 2'd3;

  // One restoring-division iteration per dividend bit.
  localparam int unsigned DIV_ITERS = 16;

  // Largest quotient whose decoded value still fits in 8 bits.
  function automatic int calc_max_q(input int scale, input int offset);
    return 255 / scale + offset;
  endfunction

endpackage

// File: rtl/math_decode_seq_div.sv
// div_restoring_seq: WIDTH-bit by constant DIVISOR restoring divider,
// one quotient bit per cycle, MSB first.
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Start             load i_Dividend and begin WIDTH iterations
//   i_Dividend          dividend captured on i_Start
//   o_Done              high during the cycle whose edge performs the final
//                       iteration; o_Quotient/o_Remainder are final after it
//   o_Quotient          quotient (shares the dividend shift register)
//   o_Remainder         remainder
module div_restoring_seq
  import math_decode_seq_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int WIDTH   = DIV_ITERS,
  parameter int REM_W   = $clog2(DIVISOR) + 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Dividend,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [REM_W-1:0] o_Remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] trial;
  logic             last;

  // Remainder is always < DIVISOR, so its top bit is zero before the shift.
  assign trial = {rem_q[REM_W-2:0], dvd_q[WIDTH-1]};
  assign last  = run_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    rem_d = rem_q;
    if (i_Start) begin
      run_d = 1'b1;
      cnt_d = '0;
      dvd_d = i_Dividend;
      rem_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (trial >= REM_W'(DIVISOR)) begin
        rem_d = trial - REM_W'(DIVISOR);
        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      end
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      rem_q <= rem_d;
    end
  end

  assign o_Done      = last;
  assign o_Quotient  = dvd_q;
  assign o_Remainder = rem_q;

endmodule

// File: rtl/math_decode_seq.sv
// math_decode_seq: recovers the lowest 8-bit source x with
// ((x/SCALE)+OFFSET)*DIVISOR == y, i.e. x = (y/DIVISOR - OFFSET)*SCALE,
// flagging words the encoder cannot produce.
// Ports:
//   i_Clk, i_Rst  clock, synchronous active-high reset
//   i_Start       request strobe, honoured only while o_Busy=0
//   i_Data        16-bit encoded word
//   o_Busy        operation in flight
//   o_Valid       one-cycle result strobe
//   o_Data        decoded value (held)
//   o_Error       word not producible by the encoder (held)
module math_decode_seq
  import math_decode_seq_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int OFFSET  = 1,
  parameter int SCALE   = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [15:0] i_Data,
  output logic        o_Busy,
  output logic        o_Valid,
  output logic [7:0]  o_Data,
  output logic        o_Error
);

  localparam int MAX_Q = calc_max_q(SCALE, OFFSET);
  localparam int REM_W = $clog2(DIVISOR) + 1;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [15:0]      diff_q, diff_d;
  logic             ezero_q, ezero_d;
  logic             ebig_q, ebig_d;
  logic             erem_q, erem_d;

  logic             div_start;
  logic             div_done;
  logic [15:0]      quot;
  logic [REM_W-1:0] rem;

  assign div_start = (state_q == ST_IDLE) && i_Start;

  div_restoring_seq #(
    .DIVISOR (DIVISOR),
    .WIDTH   (int'(DIV_ITERS)),
    .REM_W   (REM_W)
  ) u_div (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Start     (div_start),
    .i_Dividend  (i_Data),
    .o_Done      (div_done),
    .o_Quotient  (quot),
    .o_Remainder (rem)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    diff_d  = diff_q;
    ezero_d = ezero_q;
    ebig_d  = ebig_q;
    erem_d  = erem_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d = ST_DIVIDE;
          busy_d  = 1'b1;
        end
      end
      // div_done flags the final iteration edge, so SUB sees settled results.
      ST_DIVIDE: begin
        if (div_done) state_d = ST_SUB;
      end
      ST_SUB: begin
        diff_d  = quot - 16'(OFFSET);
        ezero_d = quot < 16'(OFFSET);
        ebig_d  = quot > 16'(MAX_Q);
        erem_d  = rem != '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        if (ezero_q)     data_d = '0;
        else if (ebig_q) data_d = '1;
        else             data_d = 8'(diff_q * 16'(SCALE));
        err_d   = ezero_q | ebig_q | erem_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      diff_q  <= '0;
      ezero_q <= 1'b0;
      ebig_q  <= 1'b0;
      erem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      diff_q  <= diff_d;
      ezero_q <= ezero_d;
      ebig_q  <= ebig_d;
      erem_q  <= erem_d;
    end
  end

  assign o_Busy  = busy_q;
  assign o_Valid = valid_q;
  assign o_Data  = data_q;
  assign o_Error = err_q;

endmodule

// File: tb/tb_math_decode_seq.sv
// Directed self-checking bench for math_decode_seq.
module tb_math_decode_seq;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_Start;
  logic [15:0] i_Data;
  logic        o_Busy;
  logic        o_Valid;
  logic [7:0]  o_Data;
  logic        o_Error;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_Clk = ~i_Clk;

  math_decode_seq #(
    .DIVISOR (5),
    .OFFSET  (1),
    .SCALE   (3)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Start (i_Start),
    .i_Data  (i_Data),
    .o_Busy  (o_Busy),
    .o_Valid (o_Valid),
    .o_Data  (o_Data),
    .o_Error (o_Error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after an edge; the following edge accepts the request.
  task automatic start_op(input logic [15:0] y);
    i_Start = 1'b1;
    i_Data  = y;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
  endtask

  // Counts edges until o_Valid, bounded; busy counts the cycles o_Busy=1.
  task automatic wait_valid(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_Clk); #1;
      lat++;
      if (o_Valid) return;
      if (o_Busy) busy++;
    end
  endtask

  task automatic decode(input string tag, input logic [15:0] y,
                        input logic [7:0] ed, input logic ee);
    int lat, busy;
    start_op(y);
    busy = 0;
    chk({tag, "_busy0"}, 32'(o_Busy), 1);
    wait_valid(lat, busy);
    chk({tag, "_lat"}, 32'(lat), 18);
    chk({tag, "_busycyc"}, 32'(busy + 1), 18);
    chk({tag, "_busyv"}, 32'(o_Busy), 0);
    chk({tag, "_data"}, 32'(o_Data), 32'(ed));
    chk({tag, "_err"}, 32'(o_Error), 32'(ee));
    @(posedge i_Clk); #1;
    chk({tag, "_pulse"}, 32'(o_Valid), 0);
    chk({tag, "_hold"}, 32'(o_Data), 32'(ed));
  endtask

  initial begin
    int lat, busy, vcnt;
    logic [15:0] y;
    i_Rst = 1'b1; i_Start = 1'b0; i_Data = '0;
    repeat (3) @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_valid", 32'(o_Valid), 0);
    chk("rst_data", 32'(o_Data), 0);
    chk("rst_err", 32'(o_Error), 0);

    decode("y430", 16'd430, 8'd255, 1'b0);
    decode("y5", 16'd5, 8'd0, 1'b0);
    decode("y20", 16'd20, 8'd9, 1'b0);
    decode("y0", 16'd0, 8'd0, 1'b1);
    decode("y7", 16'd7, 8'd0, 1'b1);
    decode("y13", 16'd13, 8'd3, 1'b1);
    decode("y435", 16'd435, 8'd255, 1'b1);
    decode("y65535", 16'd65535, 8'd255, 1'b1);

    for (int x = 0; x < 256; x++) begin
      y = 16'(((x / 3) + 1) * 5);
      start_op(y);
      wait_valid(lat, busy);
      chk("sweep_lat", 32'(lat), 18);
      chk("sweep_data", 32'(o_Data), 32'(3 * (x / 3)));
      chk("sweep_err", 32'(o_Error), 0);
    end

    // Starts while busy must be ignored; start in the o_Valid cycle accepted.
    start_op(16'd430);
    vcnt = 0;
    for (int k = 1; k <= 18; k++) begin
      if (k == 4 || k == 18) begin
        i_Start = 1'b1;
        i_Data  = 16'd5;
      end
      @(posedge i_Clk); #1;
      i_Start = 1'b0;
      if (k < 18 && o_Valid) vcnt++;
    end
    chk("ign_early", 32'(vcnt), 0);
    chk("ign_valid", 32'(o_Valid), 1);
    chk("ign_data", 32'(o_Data), 255);
    chk("ign_err", 32'(o_Error), 0);
    start_op(16'd20);
    chk("b2b_busy", 32'(o_Busy), 1);
    wait_valid(lat, busy);
    chk("b2b_lat", 32'(lat), 18);
    chk("b2b_data", 32'(o_Data), 9);
    chk("b2b_err", 32'(o_Error), 0);

    // Reset mid-operation aborts without a result.
    start_op(16'd430);
    repeat (9) @(posedge i_Clk);
    #1 i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    chk("abort_busy", 32'(o_Busy), 0);
    chk("abort_valid", 32'(o_Valid), 0);
    chk("abort_data", 32'(o_Data), 0);
    chk("abort_err", 32'(o_Error), 0);
    vcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge i_Clk); #1;
      if (o_Valid || o_Busy) vcnt++;
    end
    chk("abort_quiet", 32'(vcnt), 0);
    decode("post_rst", 16'd20, 8'd9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/math_decode_seq.md
Name: math_decode_seq

Overview:
- Inverse of the team's pipelined encode datapath (x -> ((x/3)+1)*5).
- Takes a 16-bit encoded word and recovers the lowest 8-bit source value that maps to it: x = (y/5 - 1)*3.
- Flags encoded words that no source value can produce.
- Division is done iteratively (restoring, 1 bit/cycle), so there is no long combinational divide path. The post-divide math is split into registered stages.

Parameters:
- DIVISOR, 5, constant divisor applied to input (must be >= 2)
- OFFSET, 1, value subtracted from quotient
- SCALE, 3, multiplier applied after subtraction

Ports:
- i_Clk  input  1  system clock, all logic on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Start  input  1  request strobe, sampled only when o_Busy=0
- i_Data  input  16  encoded word y, captured on an accepted i_Start
- o_Busy  output  1  high while an operation is in flight
- o_Valid  output  1  one-cycle pulse, result present on o_Data/o_Error
- o_Data  output  8  decoded value, held until next result or reset
- o_Error  output  1  y not producible by encoder, held with o_Data

Behaviour:
- Reset (i_Rst=1 at an edge) forces: state IDLE, o_Busy=0, o_Valid=0, o_Data=0, o_Error=0, divider regs 0. Reset mid-operation aborts the operation with no o_Valid.
- States: IDLE, DIVIDE, SUB, MUL.
- IDLE: if i_Start=1, capture i_Data into dividend shift reg, clear remainder and counter, set o_Busy=1, go to DIVIDE. i_Start=0 keeps IDLE.
- DIVIDE: 16 cycles of restoring division, MSB first, remainder 4 bits wide (ceil(log2(DIVISOR))+1).
  - Each cycle: shift dividend MSB into remainder; if remainder >= DIVISOR, subtract it and shift in quotient bit 1, else shift in 0.
  - After the 16th iteration: q = 16-bit quotient, r = remainder. Go to SUB.
- SUB (registered stage):
  - d = q - OFFSET, 16 bits.
  - err_zero = (q < OFFSET).
  - err_big = (q > MAX_Q), where MAX_Q = 255/SCALE + OFFSET = 86.
  - err_rem = (r != 0).
  - Go to MUL.
- MUL (registered stage):
  - o_Data = 0 if err_zero; 255 if err_big; otherwise (d*SCALE)[7:0].
  - o_Error = err_zero | err_big | err_rem.
  - o_Valid=1 for this one cycle; o_Busy=0; go to IDLE.
- Latency: if start is accepted at edge 0, the DIVIDE edges are 1..16, the SUB edge is 17, and the MUL edge is 18. o_Valid is high and o_Busy low during the cycle after edge 18.
- Back-to-back: i_Start in the cycle where o_Valid=1 is accepted, since o_Busy=0 then.
- i_Start while o_Busy=1 is ignored; it is not queued and does not disturb the operation.
- When err_rem only (r!=0, q in range), o_Data still carries (q-1)*SCALE, with o_Error=1.
- o_Valid is 0 in every cycle other than the one following the MUL edge.
- Width: d*SCALE fits 8 bits whenever err_zero=err_big=0. No truncation is otherwise allowed.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, DIVIDE, SUB, MUL)
  - the DIVIDE iteration count (16)
  - MAX_Q derivation
- One natural sub-module: div_restoring_seq, a 16-bit by constant iterative divider.
  - Inputs: start, dividend.
  - Outputs: done, quotient, remainder.
  - Instantiated from the DIVIDE state.

Test Plan:
- Reset, then i_Start with y=430 -> o_Valid pulse 18 cycles after the start edge, o_Data=255, o_Error=0, o_Busy high for exactly 18 cycles.
- y=5 -> o_Data=0, o_Error=0. y=20 -> o_Data=9, o_Error=0. Sweep all x 0..255 through the encode formula and back: o_Data=3*(x/3) and o_Error=0 every time.
- y=0 -> o_Data=0, o_Error=1. y=7 (q=1, r=2) -> o_Data=0, o_Error=1. y=13 (q=2, r=3) -> o_Data=3, o_Error=1.
- y=435 (q=87) -> o_Data=255, o_Error=1. y=65535 -> o_Data=255, o_Error=1.
- Start y=430, pulse i_Start with y=5 at cycles 3 and 17 -> both ignored, single result 255. Then i_Start with y=20 in the o_Valid cycle -> accepted, second result 9 arrives 18 cycles later.
- Start y=430, assert i_Rst at cycle 10 -> no o_Valid pulse, outputs 0, o_Busy=0. A new start after reset completes normally.
